// File: rtl/lshift_arbiter.sv
// Round-robin front end sharing one left shifter between clients A and B.
// The shifted result is registered and tagged with its source.
module lshift_arbiter #(
    parameter int width = 8,
    localparam int sw = $clog2(width)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [width-1:0] a_bits,
    input  logic [sw-1:0]    a_shift,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [width-1:0] b_bits,
    input  logic [sw-1:0]    b_shift,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width-1:0] o_bits,
    output logic             o_src
);

    logic             rr;
    logic             can_accept;
    logic             grant_a;
    logic             grant_b;
    logic             take_a;
    logic             take_b;
    logic [width-1:0] sel_bits;
    logic [sw-1:0]    sel_shift;
    logic [width-1:0] shifted;

    // rr = 0 gives A priority on contention, rr = 1 gives B priority
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && (!b_valid || !rr)) begin
            grant_a = 1'b1;
        end else if (b_valid) begin
            grant_b = 1'b1;
        end
    end

    assign can_accept = !o_valid || o_ready;

    // readies are held low while reset is asserted
    assign take_a  = rst && can_accept && grant_a;
    assign take_b  = rst && can_accept && grant_b;
    assign a_ready = take_a;
    assign b_ready = take_b;

    assign sel_bits  = grant_b ? b_bits  : a_bits;
    assign sel_shift = grant_b ? b_shift : a_shift;

    // shift amounts >= width fall off the top and yield zero
    assign shifted = sel_bits << sel_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid <= 1'b0;
            o_bits  <= '0;
            o_src   <= 1'b0;
            rr      <= 1'b0;
        end else if (take_a || take_b) begin
            o_valid <= 1'b1;
            o_bits  <= shifted;
            o_src   <= take_b;
            rr      <= take_a;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: doc/lshift_arbiter.md
Name: lshift_arbiter

Overview:
- Shares one generic left-shift datapath between two requesters, A and B.
- Each requester has a valid/ready request channel.
- Grants are round-robin.
- Results go out through a single registered valid/ready output channel, tagged with the source.
- Sits between client blocks and a single shifter instance, so the design does not need a shifter per client.

Parameters:
- width, 8, bit width of operands and result; legal range width >= 2.
- sw (derived, not overridable), clog2(width), width of the shift-amount fields.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- a_valid  in  1  requester A presents a request.
- a_ready  out  1  A's request is accepted this cycle.
- a_bits  in  width  A operand.
- a_shift  in  sw  A shift amount.
- b_valid  in  1  requester B presents a request.
- b_ready  out  1  B's request is accepted this cycle.
- b_bits  in  width  B operand.
- b_shift  in  sw  B shift amount.
- o_valid  out  1  result register holds a valid result.
- o_ready  in  1  downstream accepts the result.
- o_bits  out  width  shifted result.
- o_src  out  1  source of the result: 0 = A, 1 = B.

Behaviour:
- Reset, asserted asynchronously while rst = 0:
  - o_valid = 0, o_bits = 0, o_src = 0.
  - Round-robin pointer rr = 0, meaning A has priority.
  - Reset mid-transaction discards the held result.
  - No a_ready/b_ready while rst = 0.
- Release is synchronous to clk. The first grant is possible in the first cycle after release.
- Handshake:
  - A transfer happens on a channel when valid = 1 and ready = 1 at a rising edge.
  - Requesters must hold valid, bits and shift stable until accepted; the arbiter does not check this.
  - valid must not depend on ready.
- can_accept = (o_valid = 0) or (o_ready = 1). This allows full throughput: one result per cycle while downstream is ready.
- Grant logic (combinational, from current valids, rr and can_accept):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant A if rr = 0, else B.
  - a_ready = can_accept and grant A. b_ready = can_accept and grant B.
  - At most one ready is high per cycle. A ready is never high while its valid is low.
- On an accepted request:
  - o_bits <= (bits << shift) truncated to width bits.
  - o_src <= granted source; o_valid <= 1; rr <= opposite of the granted source.
- Pointer rules:
  - rr updates only on an accepted request.
  - A stalled output (o_valid = 1, o_ready = 0) freezes rr, grants and the output register.
- Shift arithmetic:
  - Zero-fill from the LSB.
  - shift = 0 passes bits unchanged.
  - When width is not a power of two, shift >= width yields all zeros (e.g. width 6, shift 7 -> 0).
- Output drain:
  - o_ready = 1 with o_valid = 1 and no new accept: o_valid <= 0 next cycle; o_bits/o_src keep their last value.
  - Drain and new accept in the same cycle: the register loads the new result and o_valid stays 1.
- Latency: exactly 1 cycle from accept to o_valid with the corresponding result.
- Fairness:
  - With both requesters continuously valid and o_ready = 1, grants alternate A, B, A, B...
  - Neither requester waits more than one other grant once the output is draining.
- o_ready while o_valid = 0 has no effect.

Test Plan:
- Reset, then idle: rst low mid-run with o_valid = 1 -> o_valid, o_bits, o_src go to 0 immediately. After release with A and B both valid, A is granted first.
- Single A, width 8: a_bits = 0x81, a_shift = 1, o_ready = 1 -> next cycle o_valid = 1, o_bits = 0x02, o_src = 0. a_ready was high for exactly 1 cycle.
- Contention, o_ready = 1: A = (0x0F, 4), B = (0x03, 2), both held valid for 4 accepts -> outputs in order:
  - 0xF0 src 0
  - 0x0C src 1
  - 0xF0 src 0
  - 0x0C src 1
  - One result per cycle, no bubbles.
- Backpressure: o_ready = 0 for 5 cycles with an A result held and B valid -> o_bits/o_src stable, a_ready = b_ready = 0 throughout. When o_ready rises, B is accepted in the same cycle and its result appears next cycle.
- Boundary shifts, width 8: shift 0 on 0xA5 -> 0xA5; shift 7 on 0xFF -> 0x80.
- Boundary shifts, width 6: shift 7 on 0x3F -> 0x00.
- Only B active for 3 requests, then A and B both valid -> B, B, B, then A is granted before B (rr points to A after B's grants).
